fwnoc_router_egress_arb: RTL
============================

// Module: fwnoc_router_egress_arb
// PURPOSE
//  Per-output-port packet arbiter for the fwnoc 2D-mesh router. Collects the five ingress-manager
//  requests destined for one egress direction (host/N/S/E/W) and grants one packet at a time.
//  Round-robin, packet-atomic: grant is held from header through last payload beat.
//  One instance per router output port, between ingress managers and the output link/FIFO.
// PARAMETERS
//  PORT_EN   5'b11111  bit k=1 lets requester k be granted (0=h,1=n,2=s,3=e,4=w); masked ports never get ready
//  PRI_RESET 0         index (0..4) of highest-priority requester after reset
// PORTS
//  clock     in   1   clock
//  reset     in   1   async active-high reset
//  h_valid   in   1   host-ingress request valid (likewise n_, s_, e_, w_)
//  h_ready   out  1   beat accepted from host ingress (likewise n_, s_, e_, w_)
//  h_dat     in   32  host-ingress data beat (likewise n_, s_, e_, w_)
//  o_valid   out  1   egress beat valid
//  o_ready   in   1   egress sink ready
//  o_dat     out  32  egress data beat
//  gnt       out  5   one-hot current grant; 0 when idle
//  busy      out  1   1 while a packet owns the output (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, ptr=PRI_RESET, remaining=0, hdr=1; o_valid=0, all *_ready=0, o_dat=0.
//  Handshake: beat transfers on o_valid&o_ready. o_valid=granted req valid, o_dat=granted req dat,
//   granted req ready=o_ready; all non-granted readies=0. o_valid never depends on o_ready.
//  States:
//   IDLE: eligible = {valids} & PORT_EN. If nonzero, pick first set bit from ptr upward (mod 5),
//    register gnt, hdr=1, go PKT. No beat moves in IDLE -> first header out >=1 cycle after valid.
//   PKT, hdr=1 (header beat): on transfer, remaining = decode(dat[3:0]); if decode==0 go IDLE
//    (header-only packet) else hdr=0.
//   PKT, hdr=0 (payload): on transfer remaining-=1; transfer with remaining==1 -> IDLE.
//   Leaving PKT: ptr = granted index+1 (mod 5), gnt=0. IDLE->grant again takes one cycle (1 bubble).
//  Size decode (header bits[3:0], 5-bit result): 0->0,1->1,2->2,3->4,4->8,5->16; codes 6..15 -> 0.
//   Packet = 1 header + decode payload beats.
//  Granted valid low mid-packet: o_valid=0, hold grant/counter (no timeout, no preemption).
//  o_ready low: hold; counter changes only on transfers.
//  Requests arriving/dropping while PKT: ignored until IDLE; granted packet is never interrupted.
//  Requester valid dropping in IDLE before grant: nothing latched, no beat moved.
//  Reset mid-packet: return to reset state immediately; partial packet discarded.
//  ptr of a masked port skips it naturally (eligible=0 for it).
//  Counter never wraps: decrement only with remaining>=1.
// TESTING
//  1 n_ only, header code 2, o_ready=1 -> gnt=5'b00010, 3 beats on o_dat in order, then busy=0.
//  2 h_,e_ valid same cycle, ptr=0, code 1 each -> h packet (2 beats), 1 bubble, e packet (2 beats); next tie prefers e+1.
//  3 code 4 packet, o_ready toggled 1/0 each cycle -> 9 beats exact, no dup/loss, gnt held throughout.
//  4 PORT_EN=5'b11110, only h_ valid -> h_ready=0 forever, o_valid=0, busy=0.
//  5 header code 0 and code 9 -> single-beat packets, return to IDLE after header.
//  6 reset asserted after 3 of 17 beats (code 5) -> o_valid=0, gnt=0 same cycle; after release next grant from PRI_RESET.

Source files
------------

// File: rtl/fwnoc_router_egress_arb.sv
// Per-output-port egress arbiter for the fwnoc mesh router: packet-atomic round-robin across the
// host/N/S/E/W ingress managers, with the grant held from header beat through last payload beat.
module fwnoc_router_egress_arb #(
  parameter logic [4:0]  PortEn   = 5'b11111,
  parameter int unsigned PriReset = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        h_valid_i,
  output logic        h_ready_o,
  input  logic [31:0] h_dat_i,
  input  logic        n_valid_i,
  output logic        n_ready_o,
  input  logic [31:0] n_dat_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_dat_i,
  input  logic        e_valid_i,
  output logic        e_ready_o,
  input  logic [31:0] e_dat_i,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [31:0] w_dat_i,
  output logic        o_valid_o,
  input  logic        o_ready_i,
  output logic [31:0] o_dat_o,
  output logic [4:0]  gnt_o,
  output logic        busy_o
);

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e      state_q;
  logic [4:0]  gnt_q;
  logic [2:0]  ptr_q;
  logic [4:0]  rem_q;
  logic        hdr_q;

  logic [4:0]  valids;
  logic [31:0] dats [5];
  logic [4:0]  eligible;
  logic [4:0]  pick_oh;
  logic [2:0]  gidx;
  logic [2:0]  ptr_next;
  logic [4:0]  size_dec;
  logic        xfer;

  function automatic logic [4:0] size_decode(input logic [3:0] code);
    logic [4:0] res;
    case (code)
      4'd1:    res = 5'd1;
      4'd2:    res = 5'd2;
      4'd3:    res = 5'd4;
      4'd4:    res = 5'd8;
      4'd5:    res = 5'd16;
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  assign valids   = {w_valid_i, e_valid_i, s_valid_i, n_valid_i, h_valid_i};
  assign eligible = valids & PortEn;

  always_comb begin
    dats[0] = h_dat_i;
    dats[1] = n_dat_i;
    dats[2] = s_dat_i;
    dats[3] = e_dat_i;
    dats[4] = w_dat_i;
  end

  // Rotating search: first eligible requester at or above ptr_q, wrapping modulo 5.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    pick_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx = 3'((int'(ptr_q) + i) % 5);
      if (!found && eligible[idx]) begin
        pick_oh[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    gidx    = '0;
    o_dat_o = '0;
    for (int i = 0; i < 5; i++) begin
      if (gnt_q[i]) begin
        gidx    = 3'(i);
        o_dat_o = o_dat_o | dats[i];
      end
    end
  end

  assign ptr_next  = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
  assign o_valid_o = |(gnt_q & valids);
  assign xfer      = o_valid_o & o_ready_i;
  assign size_dec  = size_decode(o_dat_o[3:0]);

  assign h_ready_o = gnt_q[0] & o_ready_i;
  assign n_ready_o = gnt_q[1] & o_ready_i;
  assign s_ready_o = gnt_q[2] & o_ready_i;
  assign e_ready_o = gnt_q[3] & o_ready_i;
  assign w_ready_o = gnt_q[4] & o_ready_i;
  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q == StPkt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= 3'(PriReset);
      rem_q   <= '0;
      hdr_q   <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (|eligible) begin
            gnt_q   <= pick_oh;
            hdr_q   <= 1'b1;
            state_q <= StPkt;
          end
        end
        StPkt: begin
          if (xfer) begin
            if (hdr_q) begin
              if (size_dec == 5'd0) begin
                state_q <= StIdle;
                gnt_q   <= '0;
                ptr_q   <= ptr_next;
              end else begin
                rem_q <= size_dec;
                hdr_q <= 1'b0;
              end
            end else begin
              if (rem_q != 5'd0) rem_q <= rem_q - 5'd1;
              if (rem_q == 5'd1) begin
                state_q <= StIdle;
                gnt_q   <= '0;
                ptr_q   <= ptr_next;
                hdr_q   <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
